// File: rtl/cineraria_core_nios2_div_cell_pkg.sv
// Shared definitions for the Nios II A-stage divider cell.
//   - div_state_e   : FSM states of the iterative divider
//   - DIV_WIDTH     : default operand width
//   - div_latency() : start-to-done latency for a given width
//   - DIV_LATENCY   : latency for the default width
//   - DIV_ZERO_QUOT : quotient returned for a zero divisor (all ones)
package cineraria_core_nios2_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } div_state_e;

    localparam int DIV_WIDTH = 32;

    // One PREP cycle, WIDTH ITER cycles, one FIX cycle.
    function automatic int div_latency(input int width);
        return width + 2;
    endfunction

    localparam int DIV_LATENCY = div_latency(DIV_WIDTH);

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/cineraria_core_nios2_div_cell_if.sv
// Request/response bundle between the A-stage and the divider cell.
//   A_div_start  : 1-cycle request, operands sampled with it
//   A_div_signed : 1 = div, 0 = divu
//   A_div_src1   : dividend
//   A_div_src2   : divisor
//   A_div_busy   : divider occupied (pipeline stalls on this)
//   A_div_done   : 1-cycle pulse, results valid from this cycle
//   A_div_quot   : quotient, held between operations
//   A_div_rem    : remainder, held between operations
// master = pipeline side, slave = divider side.
interface cineraria_core_nios2_div_cell_if #(
    parameter int WIDTH = 32
);
    logic             A_div_start;
    logic             A_div_signed;
    logic [WIDTH-1:0] A_div_src1;
    logic [WIDTH-1:0] A_div_src2;
    logic             A_div_busy;
    logic             A_div_done;
    logic [WIDTH-1:0] A_div_quot;
    logic [WIDTH-1:0] A_div_rem;

    modport master (
        output A_div_start,
        output A_div_signed,
        output A_div_src1,
        output A_div_src2,
        input  A_div_busy,
        input  A_div_done,
        input  A_div_quot,
        input  A_div_rem
    );

    modport slave (
        input  A_div_start,
        input  A_div_signed,
        input  A_div_src1,
        input  A_div_src2,
        output A_div_busy,
        output A_div_done,
        output A_div_quot,
        output A_div_rem
    );
endinterface

// File: rtl/cineraria_core_nios2_div_cell_step.sv
// Combinational single restoring-division step.
//   r      : partial remainder (always < d on entry)
//   q      : dividend/quotient shift register
//   d      : divisor magnitude
//   r_next : updated partial remainder
//   q_next : q shifted left with the new quotient bit in bit 0
// Kept separate so a radix-4 variant can chain two of these per clock.
module cineraria_core_nios2_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    // The shifted remainder needs one extra bit: r can be as large as
    // d-1, so 2r+1 may exceed WIDTH bits when d is above half range.
    // After a successful subtract the result is < d and fits WIDTH bits.
    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] d_ext;

    always_comb begin
        r_shift = {r, q[WIDTH-1]};
        d_ext   = {1'b0, d};
        if (r_shift >= d_ext) begin
            r_next = WIDTH'(r_shift - d_ext);
            q_next = {q[WIDTH-2:0], 1'b1};
        end else begin
            r_next = r_shift[WIDTH-1:0];
            q_next = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/cineraria_core_nios2_div_cell.sv
// Iterative radix-2 restoring divider for Nios II div/divu.
//   clk    : clock, all state on the rising edge
//   reset  : synchronous active-high reset, aborts any operation
//   div_if : slave side of the request/response bundle
// Operands are converted to magnitudes on acceptance, divided unsigned one
// quotient bit per clock, and the signs are applied as the results are
// registered. Latency is WIDTH+2 cycles regardless of operand values.
module cineraria_core_nios2_div_cell
    import cineraria_core_nios2_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    cineraria_core_nios2_div_cell_if.slave div_if
);

    localparam int LATENCY = div_latency(WIDTH);
    localparam int CW      = $clog2(WIDTH);
    // ITER runs LATENCY-2 cycles; the counter reloads with one less
    // because the exit test happens on the count==0 step.
    localparam logic [CW-1:0] COUNT_LOAD = CW'(LATENCY - 3);
    // Replicate the package constant so any WIDTH gets an all-ones value.
    localparam int ZQ_REPS = (WIDTH + DIV_WIDTH - 1) / DIV_WIDTH;
    localparam logic [WIDTH-1:0] ZERO_QUOT = WIDTH'({ZQ_REPS{DIV_ZERO_QUOT}});

    div_state_e       state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] r_reg, r_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] d_reg, d_next;
    logic             neg_q_reg, neg_q_next;
    logic             neg_r_reg, neg_r_next;
    logic             zero_div_reg, zero_div_next;
    logic [WIDTH-1:0] quot_reg, quot_next;
    logic [WIDTH-1:0] rem_reg, rem_next;

    logic [WIDTH-1:0] step_r;
    logic [WIDTH-1:0] step_q;

    logic             src1_neg;
    logic             src2_neg;

    cineraria_core_nios2_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r      (r_reg),
        .q      (q_reg),
        .d      (d_reg),
        .r_next (step_r),
        .q_next (step_q)
    );

    assign src1_neg = div_if.A_div_signed & div_if.A_div_src1[WIDTH-1];
    assign src2_neg = div_if.A_div_signed & div_if.A_div_src2[WIDTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            r_reg        <= '0;
            q_reg        <= '0;
            d_reg        <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            zero_div_reg <= 1'b0;
            quot_reg     <= '0;
            rem_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            r_reg        <= r_next;
            q_reg        <= q_next;
            d_reg        <= d_next;
            neg_q_reg    <= neg_q_next;
            neg_r_reg    <= neg_r_next;
            zero_div_reg <= zero_div_next;
            quot_reg     <= quot_next;
            rem_reg      <= rem_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        r_next        = r_reg;
        q_next        = q_reg;
        d_next        = d_reg;
        neg_q_next    = neg_q_reg;
        neg_r_next    = neg_r_reg;
        zero_div_next = zero_div_reg;
        quot_next     = quot_reg;
        rem_next      = rem_reg;

        case (state_reg)
            IDLE: begin
                if (div_if.A_div_start) begin
                    state_next = PREP;
                    // MIN negates to itself, which reads correctly as the
                    // unsigned magnitude 2^(WIDTH-1).
                    q_next     = src1_neg ? -div_if.A_div_src1 : div_if.A_div_src1;
                    d_next     = src2_neg ? -div_if.A_div_src2 : div_if.A_div_src2;
                    neg_q_next = src1_neg ^ src2_neg;
                    neg_r_next = src1_neg;
                end
            end

            PREP: begin
                r_next        = '0;
                count_next    = COUNT_LOAD;
                zero_div_next = (d_reg == '0);
                state_next    = ITER;
            end

            ITER: begin
                // A zero divisor freezes the datapath but still spends the
                // full count, so the pipeline stall length never varies.
                if (!zero_div_reg) begin
                    r_next = step_r;
                    q_next = step_q;
                end
                count_next = count_reg - 1'b1;
                if (count_reg == '0) begin
                    state_next = FIX;
                    // Results are registered here so they are already stable
                    // during the done cycle.
                    if (zero_div_reg) begin
                        quot_next = ZERO_QUOT;
                        // Re-applying the dividend sign to its magnitude
                        // restores the raw dividend.
                        rem_next  = neg_r_reg ? -q_reg : q_reg;
                    end else begin
                        quot_next = neg_q_reg ? -step_q : step_q;
                        rem_next  = neg_r_reg ? -step_r : step_r;
                    end
                end
            end

            FIX: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign div_if.A_div_busy = (state_reg != IDLE);
    assign div_if.A_div_done = (state_reg == FIX);
    assign div_if.A_div_quot = quot_reg;
    assign div_if.A_div_rem  = rem_reg;

endmodule

// File: tb/tb_cineraria_core_nios2_div_cell.sv
// Self-checking bench for the divider cell: directed corner cases, a
// start-collision sequence, mid-operation reset, and randomized div/divu
// against a reference built from plain integer arithmetic.
module tb_cineraria_core_nios2_div_cell;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    cineraria_core_nios2_div_cell_if #(.WIDTH(32)) div_if ();

    cineraria_core_nios2_div_cell #(
        .WIDTH (32)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .div_if (div_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Reference: truncating integer division, zero divisor gives all ones
    // and the raw dividend.
    function automatic void model(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic drive_start(input logic sg, input logic [31:0] a, input logic [31:0] b);
        div_if.A_div_start  = 1'b1;
        div_if.A_div_signed = sg;
        div_if.A_div_src1   = a;
        div_if.A_div_src2   = b;
    endtask

    // Called at the negedge of the accept cycle T with start still high.
    task automatic finish_op(input string tag, input logic [31:0] eq, input logic [31:0] er);
        int n;
        int busy_cnt;
        bit seen;
        n        = 1;
        busy_cnt = 0;
        seen     = 1'b0;
        @(negedge clk);
        div_if.A_div_start = 1'b0;
        while (!seen && n <= 40) begin
            if (div_if.A_div_done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (div_if.A_div_busy === 1'b1) busy_cnt++;
                @(negedge clk);
                n++;
            end
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(n), 32'd34);
        check({tag, " busy_before_done"}, 32'(busy_cnt), 32'd33);
        check({tag, " busy_in_done"}, 32'(div_if.A_div_busy), 32'd1);
        check({tag, " quot"}, div_if.A_div_quot, eq);
        check({tag, " rem"}, div_if.A_div_rem, er);
        $display("op %s: quot=0x%08h rem=0x%08h latency=%0d", tag,
                 div_if.A_div_quot, div_if.A_div_rem, n);
        @(negedge clk);
        check({tag, " idle_busy"}, 32'(div_if.A_div_busy), 32'd0);
        check({tag, " idle_done"}, 32'(div_if.A_div_done), 32'd0);
        check({tag, " quot_held"}, div_if.A_div_quot, eq);
    endtask

    task automatic run_op(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
        @(negedge clk);
        drive_start(sg, a, b);
        finish_op(tag, eq, er);
    endtask

    initial begin
        logic [31:0] mq;
        logic [31:0] mr;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        int          done_cnt;

        pass_cnt            = 0;
        total_cnt           = 0;
        reset               = 1'b1;
        div_if.A_div_start  = 1'b0;
        div_if.A_div_signed = 1'b0;
        div_if.A_div_src1   = '0;
        div_if.A_div_src2   = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(div_if.A_div_busy), 32'd0);
        check("reset done", 32'(div_if.A_div_done), 32'd0);
        check("reset quot", div_if.A_div_quot, 32'd0);
        check("reset rem", div_if.A_div_rem, 32'd0);
        reset = 1'b0;

        // Directed cases with hand-computed results.
        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        run_op("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
        run_op("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2);
        run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_op("divu_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_op("divu_1234_0", 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234);
        run_op("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        run_op("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE);

        // Starts during the operation and in the done cycle are ignored;
        // a start on the first idle cycle is accepted.
        @(negedge clk);
        drive_start(1'b0, 32'd1000, 32'd9);
        for (int n = 1; n <= 35; n++) begin
            @(negedge clk);
            if (n == 6) begin
                check("collide busy_mid", 32'(div_if.A_div_busy), 32'd1);
            end
            if (n == 34) begin
                check("collide done", 32'(div_if.A_div_done), 32'd1);
                check("collide quot", div_if.A_div_quot, 32'd111);
                check("collide rem", div_if.A_div_rem, 32'd1);
            end
            if (n == 35) begin
                check("collide idle_busy", 32'(div_if.A_div_busy), 32'd0);
                check("collide quot_kept", div_if.A_div_quot, 32'd111);
                check("collide rem_kept", div_if.A_div_rem, 32'd1);
                drive_start(1'b1, 32'hFFFF_FFB3, 32'd5);
            end else if (n == 5 || n == 34) begin
                drive_start(1'b1, 32'h7777_7777, 32'h0000_0003);
            end else begin
                div_if.A_div_start = 1'b0;
            end
        end
        finish_op("back_to_back", 32'hFFFF_FFF1, 32'hFFFF_FFFE);

        // Reset in cycle 10 of an operation aborts it.
        @(negedge clk);
        drive_start(1'b0, 32'hFFFF_0000, 32'd3);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            div_if.A_div_start = 1'b0;
            if (n == 10) begin
                check("abort busy_before", 32'(div_if.A_div_busy), 32'd1);
                reset = 1'b1;
            end
        end
        @(negedge clk);
        check("abort busy", 32'(div_if.A_div_busy), 32'd0);
        check("abort done", 32'(div_if.A_div_done), 32'd0);
        check("abort quot", div_if.A_div_quot, 32'd0);
        check("abort rem", div_if.A_div_rem, 32'd0);
        reset    = 1'b0;
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (div_if.A_div_done === 1'b1) done_cnt++;
        end
        check("abort no_done", 32'(done_cnt), 32'd0);
        $display("op abort: reset in cycle 10, done pulses afterwards=%0d", done_cnt);
        run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

        // Randomized div/divu against the arithmetic reference.
        for (int i = 0; i < 16; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 4))
                0:       b = $urandom;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'd0;
                3:       b = -($urandom_range(1, 100));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            model(sg, a, b, mq, mr);
            run_op($sformatf("rand%0d_%s_%08h_%08h", i, sg ? "div" : "divu", a, b),
                   sg, a, b, mq, mr);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
